// File: rtl/hmmm_mem_pkg.sv
// Shared types and sizing constants for the HMMM unified memory and its byte-serial loader.
package hmmm_mem_pkg;

  localparam int MEM_AW = 8;
  localparam int MEM_IW = 15;
  localparam int HI_W   = 7;
  localparam int LO_W   = 8;

  typedef enum logic [2:0] {
    L_CNT,
    L_HI,
    L_LO,
    L_SUM,
    RUN,
    ERR
  } loader_state_e;

endpackage

// File: rtl/hmmm_mem_array.sv
// 2**AW x IW storage: asynchronous read, one synchronous write port with separate hi/lo byte enables.
module hmmm_mem_array
  import hmmm_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int IW = MEM_IW
) (
  input  logic          clk_i,
  input  logic          we_hi_i,
  input  logic          we_lo_i,
  input  logic [AW-1:0] wadr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] radr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [0:(1<<AW)-1];

  // No reset: contents survive reset so a partial load stays visible until overwritten.
  always_ff @(posedge clk_i) begin
    if (we_lo_i) mem_q[wadr_i][LO_W-1:0]  <= wdata_i[LO_W-1:0];
    if (we_hi_i) mem_q[wadr_i][IW-1:LO_W] <= wdata_i[IW-1:LO_W];
  end

  assign rdata_o = mem_q[radr_i];

endmodule

// File: rtl/hmmm_mem_loader.sv
// HMMM program/data memory with byte-serial image loader; holds the CPU idle until loaded.
// Optional macro HMMM_LOADER_CHECKSUM_EN adds a trailing 8-bit wrap-sum byte and an error state.
module hmmm_mem_loader
  import hmmm_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int IW = MEM_IW
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic            ld_valid,
  input  logic [7:0]      ld_data,
  output logic            ld_ready,
  output logic            cpu_run,
  input  logic [AW-1:0]   cpu_adr,
  input  logic            cpu_we,
  input  logic [7:0]      cpu_wdata,
  output logic [HI_W-1:0] cpu_rdata_hi,
  output logic [LO_W-1:0] cpu_rdata_lo,
  output logic            ld_err
);

  loader_state_e   state_q;
  logic            ld_ready_q;
  logic            cpu_run_q;
  logic [AW:0]     rem_q;
  logic [AW-1:0]   ptr_q;
  logic [HI_W-1:0] hi_buf_q;
  logic            xfer;

  assign xfer = ld_valid & ld_ready_q;

`ifdef HMMM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       ld_err_q;
  assign ld_err = ld_err_q;
`else
  assign ld_err = 1'b0;
`endif

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q    <= L_CNT;
      ld_ready_q <= 1'b1;
      cpu_run_q  <= 1'b0;
      rem_q      <= '0;
      ptr_q      <= '0;
`ifdef HMMM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      ld_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        L_CNT: if (xfer) begin
          // A zero count byte stands for a full-depth image.
          rem_q   <= (ld_data == 8'h00) ? (AW+1)'(1 << AW) : (AW+1)'(ld_data);
          ptr_q   <= '0;
          state_q <= L_HI;
`ifdef HMMM_LOADER_CHECKSUM_EN
          sum_q   <= ld_data;
`endif
        end
        L_HI: if (xfer) begin
          state_q <= L_LO;
`ifdef HMMM_LOADER_CHECKSUM_EN
          sum_q   <= sum_q + ld_data;
`endif
        end
        L_LO: if (xfer) begin
          ptr_q <= ptr_q + 1'b1;
          rem_q <= rem_q - 1'b1;
`ifdef HMMM_LOADER_CHECKSUM_EN
          sum_q <= sum_q + ld_data;
`endif
          if (rem_q == (AW+1)'(1)) begin
`ifdef HMMM_LOADER_CHECKSUM_EN
            state_q    <= L_SUM;
`else
            state_q    <= RUN;
            ld_ready_q <= 1'b0;
            cpu_run_q  <= 1'b1;
`endif
          end else begin
            state_q <= L_HI;
          end
        end
`ifdef HMMM_LOADER_CHECKSUM_EN
        L_SUM: if (xfer) begin
          ld_ready_q <= 1'b0;
          if (sum_q == ld_data) begin
            state_q   <= RUN;
            cpu_run_q <= 1'b1;
          end else begin
            state_q  <= ERR;
            ld_err_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge ph1) begin
    if (state_q == L_HI && xfer) hi_buf_q <= ld_data[HI_W-1:0];
  end

  assign ld_ready = ld_ready_q;
  assign cpu_run  = cpu_run_q;

  logic            in_run;
  logic            we_hi;
  logic            we_lo;
  logic [AW-1:0]   wadr;
  logic [IW-1:0]   wdata;
  logic [IW-1:0]   rdata;

  // Loader and CPU never write in the same state, so RUN alone selects the write source.
  assign in_run = (state_q == RUN);
  assign we_hi  = !in_run && (state_q == L_LO) && xfer;
  assign we_lo  = in_run ? cpu_we : ((state_q == L_LO) && xfer);
  assign wadr   = in_run ? cpu_adr : ptr_q;
  assign wdata  = in_run ? {hi_buf_q, cpu_wdata} : {hi_buf_q, ld_data};

  hmmm_mem_array #(
    .AW(AW),
    .IW(IW)
  ) u_mem (
    .clk_i  (ph1),
    .we_hi_i(we_hi),
    .we_lo_i(we_lo),
    .wadr_i (wadr),
    .wdata_i(wdata),
    .radr_i (cpu_adr),
    .rdata_o(rdata)
  );

  assign cpu_rdata_hi = rdata[IW-1:LO_W];
  assign cpu_rdata_lo = rdata[LO_W-1:0];

endmodule
